// File: rtl/flash_cmd_sequencer.sv
// Expands host read/program/erase requests into SPI NOR byte transactions for a byte-level shift engine.
// Optional `FLASH_POLL_TIMEOUT_EN`: bounds RDSR polling to POLL_LIMIT polls and reports a timeout error.
module flash_cmd_sequencer #(
    parameter logic [19:0] POLL_LIMIT = 20'd1000000,
    parameter int unsigned CS_GAP     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic [8:0]  req_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        resp_valid,
    output logic [1:0]  resp_err,
    output logic        eng_valid,
    input  logic        eng_ready,
    output logic [7:0]  eng_tx,
    output logic        eng_cs_hold,
    input  logic        eng_rx_valid,
    input  logic [7:0]  eng_rx,
    output logic        busy
);
    localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [2:0] OP_READ = 3'd0;
    localparam logic [2:0] OP_PP   = 3'd1;

    if (CS_GAP < 1) begin : g_gap_chk
        $error("CS_GAP must be at least 1");
    end
    if (POLL_LIMIT == 20'd0) begin : g_poll_chk
        $error("POLL_LIMIT must be nonzero");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_WREN, S_GAP, S_CMD, S_ADDR, S_DATA, S_POLL_CMD, S_POLL_RD, S_RESP
    } state_t;

    state_t      state_q, state_d, ret_q, ret_d;
    logic [2:0]  op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [8:0]  len_q, len_d, cnt_q, cnt_d;
    logic [1:0]  acnt_q, acnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic        outst_q, outst_d;
    logic        eng_valid_d, eng_cs_hold_d, wr_ready_d, rd_valid_d, resp_valid_d;
    logic        req_ready_d, busy_d;
    logic [7:0]  eng_tx_d, rd_data_d;
    logic [1:0]  resp_err_d;
    logic        hs, rx_done, send, tx_hold, is_erase, last_data;
    logic [7:0]  tx_byte;
`ifdef FLASH_POLL_TIMEOUT_EN
    logic [19:0] pcnt_q, pcnt_d;
`endif

    function automatic logic [7:0] opcode(input logic [2:0] op);
        case (op)
            3'd0:    opcode = 8'h03;
            3'd1:    opcode = 8'h02;
            3'd2:    opcode = 8'h20;
            3'd3:    opcode = 8'h52;
            default: opcode = 8'hD8;
        endcase
    endfunction

    // State, request context and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;      ret_q <= S_IDLE;
            op_q <= '0; addr_q <= '0; len_q <= '0; cnt_q <= '0;
            acnt_q <= '0; gcnt_q <= '0; outst_q <= 1'b0;
            eng_valid <= 1'b0; eng_tx <= '0; eng_cs_hold <= 1'b0;
            wr_ready <= 1'b0; rd_valid <= 1'b0; rd_data <= '0;
            resp_valid <= 1'b0; resp_err <= '0; req_ready <= 1'b1; busy <= 1'b0;
`ifdef FLASH_POLL_TIMEOUT_EN
            pcnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;     ret_q <= ret_d;
            op_q <= op_d; addr_q <= addr_d; len_q <= len_d; cnt_q <= cnt_d;
            acnt_q <= acnt_d; gcnt_q <= gcnt_d; outst_q <= outst_d;
            eng_valid <= eng_valid_d; eng_tx <= eng_tx_d; eng_cs_hold <= eng_cs_hold_d;
            wr_ready <= wr_ready_d; rd_valid <= rd_valid_d; rd_data <= rd_data_d;
            resp_valid <= resp_valid_d; resp_err <= resp_err_d;
            req_ready <= req_ready_d; busy <= busy_d;
`ifdef FLASH_POLL_TIMEOUT_EN
            pcnt_q <= pcnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q; ret_d = ret_q;
        op_d = op_q; addr_d = addr_q; len_d = len_q; cnt_d = cnt_q;
        acnt_d = acnt_q; gcnt_d = gcnt_q; outst_d = outst_q;
        eng_valid_d = eng_valid; eng_tx_d = eng_tx; eng_cs_hold_d = eng_cs_hold;
        wr_ready_d = 1'b0; rd_valid_d = 1'b0; rd_data_d = rd_data; resp_err_d = resp_err;
        send = 1'b0; tx_byte = 8'h00; tx_hold = 1'b0;
`ifdef FLASH_POLL_TIMEOUT_EN
        pcnt_d = pcnt_q;
`endif
        hs        = eng_valid & eng_ready;
        rx_done   = outst_q & eng_rx_valid;
        is_erase  = (op_q != OP_READ) && (op_q != OP_PP);
        last_data = (cnt_q == len_q - 9'd1);

        // One byte in flight: valid drops on handshake, next offer waits for its rx
        if (hs) begin
            eng_valid_d = 1'b0;
            outst_d     = 1'b1;
        end
        if (rx_done) outst_d = 1'b0;

        case (state_q)
            S_IDLE: if (req_valid && req_ready) begin
                op_d = req_op; addr_d = req_addr;
                len_d = (req_len == 9'd0) ? 9'd256 : req_len;
                cnt_d = '0; acnt_d = '0;
`ifdef FLASH_POLL_TIMEOUT_EN
                pcnt_d = '0;
`endif
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (op_q > 3'd4) begin
                    resp_err_d = 2'd1; state_d = S_RESP;
                end else if (op_q == OP_PP &&
                             ({2'b00, addr_q[7:0]} + {1'b0, len_q}) > 10'd256) begin
                    resp_err_d = 2'd2; state_d = S_RESP;
                end else if (op_q == OP_READ) begin
                    state_d = S_CMD;
                end else begin
                    state_d = S_WREN;
                end
            end
            S_WREN: begin
                send = 1'b1; tx_byte = 8'h06; tx_hold = 1'b0;
                if (rx_done) begin state_d = S_GAP; ret_d = S_CMD; gcnt_d = '0; end
            end
            S_GAP: begin
                if (gcnt_q == GW'(CS_GAP - 1)) state_d = ret_q;
                else gcnt_d = gcnt_q + GW'(1);
            end
            S_CMD: begin
                send = 1'b1; tx_byte = opcode(op_q); tx_hold = 1'b1;
                if (rx_done) begin state_d = S_ADDR; acnt_d = '0; end
            end
            S_ADDR: begin
                send = 1'b1;
                tx_byte = (acnt_q == 2'd0) ? addr_q[23:16] :
                          (acnt_q == 2'd1) ? addr_q[15:8] : addr_q[7:0];
                tx_hold = !(acnt_q == 2'd2 && is_erase);
                if (rx_done) begin
                    if (acnt_q == 2'd2) begin
                        cnt_d = '0;
                        if (is_erase) begin
                            state_d = S_GAP; ret_d = S_POLL_CMD; gcnt_d = '0;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        acnt_d = acnt_q + 2'd1;
                    end
                end
            end
            S_DATA: begin
                tx_hold = !last_data;
                if (op_q == OP_READ) begin
                    send = 1'b1; tx_byte = 8'h00;
                    if (rx_done) begin
                        rd_valid_d = 1'b1; rd_data_d = eng_rx; cnt_d = cnt_q + 9'd1;
                        if (last_data) begin resp_err_d = 2'd0; state_d = S_RESP; end
                    end
                end else begin
                    // Program data stalls with CS held low until the host supplies a byte
                    send = wr_valid; tx_byte = wr_data;
                    if (hs) wr_ready_d = 1'b1;
                    if (rx_done) begin
                        cnt_d = cnt_q + 9'd1;
                        if (last_data) begin state_d = S_GAP; ret_d = S_POLL_CMD; gcnt_d = '0; end
                    end
                end
            end
            S_POLL_CMD: begin
                send = 1'b1; tx_byte = 8'h05; tx_hold = 1'b1;
                if (rx_done) state_d = S_POLL_RD;
            end
            S_POLL_RD: begin
                send = 1'b1; tx_byte = 8'h00; tx_hold = 1'b0;
                if (rx_done) begin
                    if (!eng_rx[0]) begin
                        resp_err_d = 2'd0; state_d = S_RESP;
                    end else begin
`ifdef FLASH_POLL_TIMEOUT_EN
                        if (pcnt_q == POLL_LIMIT - 20'd1) begin
                            resp_err_d = 2'd3; state_d = S_RESP;
                        end else begin
                            if (pcnt_q != '1) pcnt_d = pcnt_q + 20'd1;
                            state_d = S_GAP; ret_d = S_POLL_CMD; gcnt_d = '0;
                        end
`else
                        state_d = S_GAP; ret_d = S_POLL_CMD; gcnt_d = '0;
`endif
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (send && !eng_valid && !outst_q) begin
            eng_valid_d = 1'b1; eng_tx_d = tx_byte; eng_cs_hold_d = tx_hold;
        end

        resp_valid_d = (state_d == S_RESP);
        req_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
    end
endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Randomized bench for flash_cmd_sequencer: a behavioural SPI engine and program-data source
// plus a byte-sequence model built from the flash command rules.
module tb_flash_cmd_sequencer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [2:0]  req_op = '0;
    logic [23:0] req_addr = '0;
    logic [8:0]  req_len = '0;
    logic [7:0]  wr_data;
    logic        wr_valid, wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid, resp_valid, busy;
    logic [1:0]  resp_err;
    logic        eng_valid, eng_ready, eng_cs_hold, eng_rx_valid;
    logic [7:0]  eng_tx, eng_rx;

    int n_pass = 0, n_checks = 0, n_fail = 0;
    logic [7:0] rx_script [0:16383];
    logic [7:0] wr_script [0:16383];
    int wr_lim = 0, wr_idx = 0, nvalid = 0, resp_cnt = 0;
    bit proto_err = 1'b0;
    logic [7:0] tx_log[$];
    logic       cs_log[$];
    logic [7:0] rd_log[$];

    flash_cmd_sequencer #(.POLL_LIMIT(20'd3), .CS_GAP(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .resp_valid(resp_valid), .resp_err(resp_err),
        .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_tx(eng_tx), .eng_cs_hold(eng_cs_hold),
        .eng_rx_valid(eng_rx_valid), .eng_rx(eng_rx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SPI shift engine: random ready, 1-4 cycle rx latency, protocol watchdog
    initial begin
        int cnt = 0;
        bit outst = 1'b0, pv = 1'b0, pr = 1'b0, pcs = 1'b0;
        logic [7:0] pend = '0, ptx = '0;
        eng_ready = 1'b0; eng_rx_valid = 1'b0; eng_rx = '0;
        forever begin
            @(negedge clk);
            eng_rx_valid = 1'b0;
            if (rst) begin
                outst = 1'b0; eng_ready = 1'b0; pv = 1'b0; pr = 1'b0;
                continue;
            end
            if (eng_valid) nvalid++;
            if (eng_valid && outst) proto_err = 1'b1;
            if (pv && !pr && (!eng_valid || eng_tx !== ptx || eng_cs_hold !== pcs)) proto_err = 1'b1;
            if (outst) begin
                cnt--;
                if (cnt == 0) begin eng_rx_valid = 1'b1; eng_rx = pend; outst = 1'b0; end
            end
            eng_ready = ($urandom_range(0, 3) != 0);
            if (eng_valid && eng_ready) begin
                pend = rx_script[tx_log.size() % 16384];
                tx_log.push_back(eng_tx);
                cs_log.push_back(eng_cs_hold);
                outst = 1'b1;
                cnt = int'($urandom_range(1, 4));
            end
            pv = eng_valid; pr = eng_ready; ptx = eng_tx; pcs = eng_cs_hold;
        end
    end

    // Program data source: holds a byte until wr_ready, then idles one cycle
    initial begin
        bit drop = 1'b0;
        wr_valid = 1'b0; wr_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin wr_valid = 1'b0; drop = 1'b0; continue; end
            if (wr_ready) begin wr_idx++; drop = 1'b1; end
            else if (drop) begin wr_valid = 1'b0; drop = 1'b0; end
            else if (wr_idx < wr_lim) begin wr_valid = 1'b1; wr_data = wr_script[wr_idx % 16384]; end
            else wr_valid = 1'b0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid) rd_log.push_back(rd_data);
            if (resp_valid) resp_cnt++;
        end
    end

    task automatic start_req(input logic [2:0] op, input logic [23:0] a, input logic [8:0] l);
        int c = 0;
        @(negedge clk);
        while (!req_ready && c < 1000) begin @(negedge clk); c++; end
        chk("req_ready_before_request", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr = a; req_len = l;
        @(negedge clk);
        req_valid = 1'b0; req_op = 3'($urandom); req_addr = 24'($urandom); req_len = 9'($urandom);
    endtask

    // Builds the expected byte stream from the command rules, runs one request and compares
    task automatic run(input string tag, input logic [2:0] op, input logic [23:0] a,
                       input logic [8:0] l, input int wips, input bit stuck, input bit dir_rd);
        int tb = tx_log.size(), rb = rd_log.size(), wb = wr_idx, vb = nvalid;
        int L = (l == 9'd0) ? 256 : int'(l);
        int eerr, npoll, c, bad, badcs, nt, nrd;
        logic [7:0] etx[$];
        logic       ecs[$];
        logic [7:0] erd[$];
        logic [7:0] d;
        for (int i = 0; i < 600; i++) rx_script[(tb + i) % 16384] = 8'($urandom);
        if (op > 3'd4) eerr = 1;
        else if (op == 3'd1 && int'(a[7:0]) + L > 256) eerr = 2;
        else begin
            eerr = stuck ? 3 : 0;
            if (op != 3'd0) begin etx.push_back(8'h06); ecs.push_back(1'b0); end
            case (op)
                3'd0: etx.push_back(8'h03);
                3'd1: etx.push_back(8'h02);
                3'd2: etx.push_back(8'h20);
                3'd3: etx.push_back(8'h52);
                default: etx.push_back(8'hD8);
            endcase
            ecs.push_back(1'b1);
            etx.push_back(a[23:16]); ecs.push_back(1'b1);
            etx.push_back(a[15:8]);  ecs.push_back(1'b1);
            etx.push_back(a[7:0]);   ecs.push_back(op < 3'd2);
            if (op == 3'd0) begin
                for (int i = 0; i < L; i++) begin
                    d = dir_rd ? 8'(8'hAA + 8'h11 * i) : 8'($urandom);
                    rx_script[(tb + etx.size()) % 16384] = d;
                    erd.push_back(d);
                    etx.push_back(8'h00); ecs.push_back(i != L - 1);
                end
            end else begin
                if (op == 3'd1) begin
                    for (int i = 0; i < L; i++) begin
                        d = 8'($urandom);
                        wr_script[(wb + i) % 16384] = d;
                        etx.push_back(d); ecs.push_back(i != L - 1);
                    end
                end
                npoll = stuck ? 3 : wips + 1;
                for (int k = 0; k < npoll; k++) begin
                    etx.push_back(8'h05); ecs.push_back(1'b1);
                    d = 8'($urandom);
                    rx_script[(tb + etx.size()) % 16384] = (stuck || k < wips) ? (d | 8'h01) : (d & 8'hFE);
                    etx.push_back(8'h00); ecs.push_back(1'b0);
                end
            end
        end
        wr_lim = wb + ((op == 3'd1 && eerr == 0) ? L : 0);
        start_req(op, a, l);
        c = 0;
        while (!resp_valid && c < 20000) begin @(negedge clk); c++; end
        chk({tag, " resp_seen"}, resp_valid, 1);
        if (eerr == 1 || eerr == 2) begin
            chk({tag, " reject_latency_ok"}, (c <= 3), 1);
            chk({tag, " eng_valid_cycles"}, nvalid - vb, 0);
        end
        chk({tag, " resp_err"}, resp_err, eerr);
        chk({tag, " busy_at_resp"}, busy, 1);
        chk({tag, " req_ready_at_resp"}, req_ready, 0);
        @(negedge clk);
        chk({tag, " req_ready_after"}, req_ready, 1);
        chk({tag, " resp_single_cycle"}, resp_valid, 0);
        nt = tx_log.size() - tb;
        chk({tag, " tx_count"}, nt, etx.size());
        bad = 0; badcs = 0;
        for (int i = 0; i < etx.size() && i < nt; i++) begin
            if (tx_log[tb + i] !== etx[i]) bad++;
            if (cs_log[tb + i] !== ecs[i]) badcs++;
        end
        chk({tag, " tx_byte_errors"}, bad, 0);
        chk({tag, " cs_hold_errors"}, badcs, 0);
        nrd = rd_log.size() - rb;
        chk({tag, " rd_count"}, nrd, erd.size());
        bad = 0;
        for (int i = 0; i < erd.size() && i < nrd; i++) if (rd_log[rb + i] !== erd[i]) bad++;
        chk({tag, " rd_data_errors"}, bad, 0);
        chk({tag, " wr_ready_pulses"}, wr_idx - wb, wr_lim - wb);
    endtask

    initial begin
        int c, rc, tb;
        logic [2:0] op;
        logic [23:0] a;
        logic [8:0] l;
        #12;
        chk("rst req_ready", req_ready, 1);
        chk("rst eng_valid", eng_valid, 0);
        chk("rst eng_tx", eng_tx, 0);
        chk("rst eng_cs_hold", eng_cs_hold, 0);
        chk("rst wr_ready", wr_ready, 0);
        chk("rst rd_valid", rd_valid, 0);
        chk("rst rd_data", rd_data, 0);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst resp_err", resp_err, 0);
        chk("rst busy", busy, 0);
        @(negedge clk); #2 rst = 1'b0;

        run("read_012345", 3'd0, 24'h012345, 9'd4, 0, 1'b0, 1'b1);
        run("se_001000", 3'd2, 24'h001000, 9'd0, 2, 1'b0, 1'b0);
        run("pp_0000f0", 3'd1, 24'h0000F0, 9'd16, 1, 1'b0, 1'b0);
        run("pp_cross", 3'd1, 24'h0000F1, 9'd16, 0, 1'b0, 1'b0);
        run("illegal_op6", 3'd6, 24'h000000, 9'd1, 0, 1'b0, 1'b0);
        run("pp_full_page", 3'd1, 24'h123400, 9'd0, 0, 1'b0, 1'b0);
        run("read_len256", 3'd0, 24'hFFFFFF, 9'd0, 0, 1'b0, 1'b0);
`ifdef FLASH_POLL_TIMEOUT_EN
        run("be64_timeout", 3'd4, 24'h450000, 9'd0, 0, 1'b1, 1'b0);
`endif

        // Reset during the address phase of a BE32
        tb = tx_log.size(); rc = resp_cnt;
        start_req(3'd3, 24'h0A8000, 9'd0);
        c = 0;
        while (tx_log.size() < tb + 3 && c < 2000) begin @(negedge clk); c++; end
        chk("rst_mid reached_addr", (tx_log.size() >= tb + 3), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid eng_valid", eng_valid, 0);
        chk("rst_mid busy", busy, 0);
        chk("rst_mid req_ready", req_ready, 1);
        chk("rst_mid resp_valid", resp_valid, 0);
        @(negedge clk); #2 rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_mid no_resp", resp_cnt - rc, 0);
        run("read_after_rst", 3'd0, 24'h00ABCD, 9'd5, 0, 1'b0, 1'b0);

        for (int it = 0; it < 12; it++) begin
            op = 3'($urandom_range(0, 5));
            if (op == 3'd5) op = 3'($urandom_range(5, 7));
            l = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(1, 24));
            a = 24'($urandom);
            if (op == 3'd1 && $urandom_range(0, 1) == 1)
                a[7:0] = 8'($urandom_range(0, 256 - ((l == 9'd0) ? 256 : int'(l))));
            run($sformatf("rand%0d", it), op, a, l, int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        chk("engine_protocol", proto_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/flash_cmd_sequencer.md
Name: flash_cmd_sequencer

Overview:
Command sequencer for the PMOD serial NOR flash.
- Accepts one high-level request at a time from the host: read, page program, sector erase, 32 kB or 64 kB block erase.
- Expands it into the byte sequence the flash requires:
  - write-enable first, for program and erase;
  - opcode, 24-bit address, then data;
  - status-register polling until the write completes.
- Drives the byte-level SPI shift engine through a valid/ready byte handshake. It never touches the SPI pins directly.

Parameters:
- POLL_LIMIT, 20'd1000000: maximum RDSR polls before timeout (used only with the optional feature).
- CS_GAP, 4: idle cycles between chip-select release and the next transaction start (minimum 1).

Ports:
- clk, input, 1: single clock.
- rst, input, 1: asynchronous, active-high reset.
- req_valid, input, 1: host request valid.
- req_ready, output, 1: sequencer can accept a request (high only in IDLE).
- req_op, input, 3: 0 READ(03h), 1 PP(02h), 2 SE(20h), 3 BE32(52h), 4 BE64(D8h); 5-7 illegal.
- req_addr, input, 24: flash byte address.
- req_len, input, 9: data byte count for READ/PP, 1..256; 0 means 256.
- wr_data, input, 8: program data stream.
- wr_valid, input, 1: program data valid.
- wr_ready, output, 1: program byte consumed this cycle.
- rd_data, output, 8: read data byte.
- rd_valid, output, 1: one-cycle strobe per read byte; no backpressure.
- resp_valid, output, 1: one-cycle completion strobe.
- resp_err, output, 2: 0 ok, 1 illegal op, 2 page crossing, 3 timeout. Valid with resp_valid.
- eng_valid, output, 1: byte offered to the shift engine.
- eng_ready, input, 1: engine accepts the byte (transfer when eng_valid & eng_ready).
- eng_tx, output, 8: byte to shift out, MSB first.
- eng_cs_hold, output, 1: 1 = keep CS low after this byte; 0 = release CS after this byte.
- eng_rx_valid, input, 1: engine finished a byte. Exactly one pulse per accepted byte.
- eng_rx, input, 8: byte shifted in, valid with eng_rx_valid.
- busy, output, 1: high whenever the state is not IDLE.

Behaviour:
- Reset values:
  - req_ready=1 (after reset, IDLE).
  - eng_valid=0, eng_tx=0, eng_cs_hold=0.
  - wr_ready=0, rd_valid=0, rd_data=0.
  - resp_valid=0, resp_err=0, busy=0.
  - All counters 0.
- Rules that apply throughout:
  - Asserting rst mid-operation aborts immediately; no resp_valid is issued. The engine shares rst and releases CS.
  - One byte outstanding at a time. After an eng handshake, eng_valid stays low until eng_rx_valid.
  - eng_tx and eng_cs_hold are stable while eng_valid is high and eng_ready is low.
  - All outputs are registered.
- States: IDLE, CHECK, WREN, GAP, CMD, ADDR, DATA, POLL_CMD, POLL_RD, RESP.
- IDLE: on req_valid & req_ready, latch op, address and length (0 becomes 256) -> CHECK.
- CHECK (1 cycle):
  - Illegal op -> RESP with err=1.
  - PP with addr[7:0] + len > 256 -> RESP with err=2.
  - READ -> CMD.
  - Otherwise -> WREN.
  - No engine bytes are issued when the request is rejected.
- WREN: send 06h with cs_hold=0. After rx -> GAP -> CMD.
- GAP: count CS_GAP cycles, then go to the stored next state.
- CMD: send the opcode with cs_hold=1.
  - SE/BE: -> ADDR.
  - READ/PP: -> ADDR.
- ADDR: send addr[23:16], addr[15:8], addr[7:0] in that order (2-bit counter).
  - Last address byte has cs_hold=0 for erase; 1 otherwise.
  - Erase -> GAP -> POLL_CMD.
  - READ/PP -> DATA.
- DATA, READ:
  - Send 00h dummy bytes; cs_hold=0 on the final byte only.
  - Each eng_rx_valid drives rd_data=eng_rx and rd_valid=1 for one cycle.
  - After len bytes -> RESP with err=0.
- DATA, PP:
  - eng_valid = wr_valid, eng_tx = wr_data.
  - wr_ready = eng_valid & eng_ready, so a byte is consumed on the handshake.
  - If wr_valid is low, stall with CS held low, indefinitely.
  - cs_hold=0 on byte len.
  - After the last rx -> GAP -> POLL_CMD.
- POLL_CMD: send 05h with cs_hold=1 -> POLL_RD.
- POLL_RD: send 00h with cs_hold=0. On rx:
  - bit0 (WIP) = 0 -> RESP with err=0.
  - Otherwise increment the poll counter -> GAP -> POLL_CMD.
- RESP: resp_valid=1 for one cycle -> IDLE. req_ready rises the following cycle.
- Counters:
  - Data counter: 9 bits, compared against latched len.
  - Address counter saturates at 2.
  - Poll counter: 20 bits, saturating.
- Simultaneous events: eng_rx_valid and a new eng_ready in the same cycle are legal. The next byte is offered the cycle after rx.

Optional Feature:
- FLASH_POLL_TIMEOUT_EN defined: in POLL_RD, if WIP=1 and the poll counter reaches POLL_LIMIT-1 -> RESP with err=3, without further polling.
- Not defined: polls indefinitely; err=3 is never produced; the poll counter logic is omitted.

Test Plan:
- READ at 0x012345, len=4, engine returning AA,BB,CC,DD on data bytes -> eng_tx sequence 03,01,23,45,00x4. cs_hold=0 only on the 8th byte. rd_valid pulses with AA..DD. resp_err=0. No 06h issued.
- SE at 0x001000, engine returns WIP=1 twice then 0 -> eng_tx sequence 06 | 20,00,10,00 | 05,00 | 05,00 | 05,00. CS released after 06, after the address, and after each status byte. resp_err=0.
- PP at 0x0000F0, len=16, wr_valid gapped every other cycle -> 06 | 02,00,00,F0, 16 data bytes in order with CS held through the stalls, then polling. Exactly 16 wr_ready pulses.
- PP at 0x0000F1, len=16 -> resp_err=2 within 3 cycles of acceptance. eng_valid never asserted. Illegal op 6 -> resp_err=1.
- With FLASH_POLL_TIMEOUT_EN and POLL_LIMIT=3, BE64 with WIP stuck at 1 -> exactly 3 RDSR transactions, then resp_err=3.
- Assert rst during ADDR of a BE32 -> next cycle: eng_valid=0, busy=0, req_ready=1, resp_valid=0. A following READ completes normally.
